// File: rtl/game_timer_pkg.sv
// Shared types, widths and helpers for the game round countdown timer.
package game_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    // Remaining seconds fit 0..5999 in 13 bits; additions use one extra bit
    localparam int SEC_W = 13;
    localparam int SUM_W = SEC_W + 1;

    // Add a bonus to the remaining time and clamp the result at the ceiling
    function automatic logic [SEC_W-1:0] sat_add(input logic [SEC_W-1:0] base,
                                                 input int bonus,
                                                 input int ceiling);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, base} + SUM_W'(bonus);
        if (sum > SUM_W'(ceiling)) begin
            return SEC_W'(ceiling);
        end
        return sum[SEC_W-1:0];
    endfunction

endpackage

// File: rtl/sec_to_mmss.sv
// Registered conversion of binary seconds into four MM:SS BCD digits.
module sec_to_mmss
    import game_timer_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic [SEC_W-1:0] sec,
    output bcd_t             min_tens,
    output bcd_t             min_ones,
    output bcd_t             sec_tens,
    output bcd_t             sec_ones
);

    bcd_t min_tens_d;
    bcd_t min_ones_d;
    bcd_t sec_tens_d;
    bcd_t sec_ones_d;

    // Split the seconds count by constant divisors: 600 s per ten minutes, 60 s per minute, 10 s per tens digit
    always_comb begin
        min_tens_d = 4'(sec / SEC_W'(600));
        min_ones_d = 4'((sec % SEC_W'(600)) / SEC_W'(60));
        sec_tens_d = 4'((sec % SEC_W'(60)) / SEC_W'(10));
        sec_ones_d = 4'(sec % SEC_W'(10));
    end

    // Single register stage so the digit outputs are glitch-free for the 7-segment decoders
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
        end else begin
            min_tens <= min_tens_d;
            min_ones <= min_ones_d;
            sec_tens <= sec_tens_d;
            sec_ones <= sec_ones_d;
        end
    end

endmodule

// File: rtl/game_countdown_timer.sv
// Game round countdown timer: consumes one-second ticks, supports start,
// pause, bonus time and low-time warning, and drives MM:SS BCD digits.
module game_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int START_SEC = 120,
    parameter int BONUS_SEC = 10,
    parameter int WARN_SEC  = 10,
    parameter int MAX_SEC   = 5999
) (
    input  logic clk,
    input  logic resetN,
    input  logic tick,
    input  logic start,
    input  logic pause_tgl,
    input  logic add_time,
    output bcd_t min_tens,
    output bcd_t min_ones,
    output bcd_t sec_tens,
    output bcd_t sec_ones,
    output logic running,
    output logic expired,
    output logic time_up,
    output logic warning,
    output logic warn_blink
);

    timer_state_t     state;
    timer_state_t     state_d;
    logic [SEC_W-1:0] rem;
    logic [SEC_W-1:0] rem_d;
    logic             pending;
    logic             pending_d;
    logic             time_up_d;
    logic             warning_d;
    logic             blink_d;
    logic             consumed;

    // Next-state logic: start dominates, ticks are judged against the current state,
    // and a tick colliding with a bonus is held one cycle so no second is lost
    always_comb begin
        state_d   = state;
        rem_d     = rem;
        pending_d = pending;
        time_up_d = 1'b0;
        consumed  = 1'b0;
        if (start) begin
            state_d   = RUNNING;
            rem_d     = SEC_W'(START_SEC);
            pending_d = 1'b0;
        end else begin
            case (state)
                RUNNING: begin
                    if (pause_tgl) begin
                        state_d = PAUSED;
                    end
                    if (add_time) begin
                        rem_d     = sat_add(rem, BONUS_SEC, MAX_SEC);
                        pending_d = pending | tick;
                    end else if (pending || tick) begin
                        consumed  = 1'b1;
                        pending_d = pending & tick;
                        if (rem > SEC_W'(1)) begin
                            rem_d = rem - SEC_W'(1);
                        end else begin
                            rem_d     = '0;
                            state_d   = EXPIRED;
                            time_up_d = 1'b1;
                            pending_d = 1'b0;
                        end
                    end
                end
                PAUSED: begin
                    pending_d = 1'b0;
                    if (pause_tgl) begin
                        state_d = RUNNING;
                    end
                    if (add_time) begin
                        rem_d = sat_add(rem, BONUS_SEC, MAX_SEC);
                    end
                end
                default: begin
                    pending_d = 1'b0;
                end
            endcase
        end
        warning_d = ((state_d == RUNNING) || (state_d == PAUSED)) &&
                    (rem_d != '0) && (rem_d <= SEC_W'(WARN_SEC));
        blink_d   = (warning_d && !start) ? (warn_blink ^ consumed) : 1'b0;
    end

    // State, remaining time and all status flags are registered together so they line up
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            rem        <= '0;
            pending    <= 1'b0;
            running    <= 1'b0;
            expired    <= 1'b0;
            time_up    <= 1'b0;
            warning    <= 1'b0;
            warn_blink <= 1'b0;
        end else begin
            state      <= state_d;
            rem        <= rem_d;
            pending    <= pending_d;
            running    <= (state_d == RUNNING);
            expired    <= (state_d == EXPIRED);
            time_up    <= time_up_d;
            warning    <= warning_d;
            warn_blink <= blink_d;
        end
    end

    sec_to_mmss u_sec_to_mmss (
        .clk      (clk),
        .resetN   (resetN),
        .sec      (rem),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones)
    );

endmodule

// File: tb/tb_game_countdown_timer.sv
// Self-checking bench for game_countdown_timer with a behavioural round model.
module tb_game_countdown_timer;

    localparam int START = 5;
    localparam int BONUS = 3;
    localparam int WARN  = 2;
    localparam int MAXS  = 5999;

    logic       clk = 1'b0;
    logic       resetN;
    logic       tick, start, pause_tgl, add_time;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, expired, time_up, warning, warn_blink;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the round
    int m_rem;
    int m_disp;
    int m_owed;
    bit m_run, m_pause, m_done, m_time_up, m_warn, m_blink;

    game_countdown_timer #(
        .START_SEC (START),
        .BONUS_SEC (BONUS),
        .WARN_SEC  (WARN),
        .MAX_SEC   (MAXS)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .tick       (tick),
        .start      (start),
        .pause_tgl  (pause_tgl),
        .add_time   (add_time),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .expired    (expired),
        .time_up    (time_up),
        .warning    (warning),
        .warn_blink (warn_blink)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic modelReset();
        m_rem = 0; m_disp = 0; m_owed = 0;
        m_run = 0; m_pause = 0; m_done = 0;
        m_time_up = 0; m_warn = 0; m_blink = 0;
    endtask

    task automatic modelStep(input bit t, input bit s, input bit p, input bit a);
        bit used;
        used = 0;
        m_time_up = 0;
        m_disp = m_rem;
        if (s) begin
            m_run = 1; m_pause = 0; m_done = 0; m_rem = START; m_owed = 0;
        end else if (m_run) begin
            if (p) begin
                m_run = 0; m_pause = 1;
            end
            if (a) begin
                m_rem  = (m_rem + BONUS > MAXS) ? MAXS : m_rem + BONUS;
                m_owed = m_owed + int'(t);
            end else if (m_owed + int'(t) > 0) begin
                used   = 1;
                m_owed = m_owed + int'(t) - 1;
                if (m_rem > 1) begin
                    m_rem = m_rem - 1;
                end else begin
                    m_rem = 0; m_done = 1; m_run = 0; m_pause = 0; m_time_up = 1;
                end
            end
            if (!m_run) m_owed = 0;
        end else if (m_pause) begin
            if (p) begin
                m_run = 1; m_pause = 0;
            end
            if (a) m_rem = (m_rem + BONUS > MAXS) ? MAXS : m_rem + BONUS;
        end
        m_warn  = (m_run || m_pause) && m_rem != 0 && m_rem <= WARN;
        m_blink = (m_warn && !s) ? (m_blink ^ used) : 1'b0;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkNib(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Digits show the remaining time as it stood one cycle earlier
    task automatic checkOutput(input string step);
        int mm, ss;
        mm = m_disp / 60;
        ss = m_disp % 60;
        checkNib({step, ".min_tens"}, min_tens, 4'(mm / 10));
        checkNib({step, ".min_ones"}, min_ones, 4'(mm % 10));
        checkNib({step, ".sec_tens"}, sec_tens, 4'(ss / 10));
        checkNib({step, ".sec_ones"}, sec_ones, 4'(ss % 10));
        checkBit({step, ".running"}, running, m_run);
        checkBit({step, ".expired"}, expired, m_done);
        checkBit({step, ".time_up"}, time_up, m_time_up);
        checkBit({step, ".warning"}, warning, m_warn);
        checkBit({step, ".warn_blink"}, warn_blink, m_blink);
    endtask

    // One clock cycle with the given pulses, then the model follows
    task automatic applyStimulus(input bit t, input bit s, input bit p, input bit a);
        tick = t; start = s; pause_tgl = p; add_time = a;
        @(posedge clk);
        #1;
        tick = 0; start = 0; pause_tgl = 0; add_time = 0;
        modelStep(t, s, p, a);
    endtask

    task automatic stepCheck(input string step, input bit t, input bit s, input bit p, input bit a);
        applyStimulus(t, s, p, a);
        checkOutput(step);
    endtask

    task automatic checkAllZero(input string step);
        checkNib({step, ".min_tens"}, min_tens, 4'd0);
        checkNib({step, ".min_ones"}, min_ones, 4'd0);
        checkNib({step, ".sec_tens"}, sec_tens, 4'd0);
        checkNib({step, ".sec_ones"}, sec_ones, 4'd0);
        checkBit({step, ".running"}, running, 1'b0);
        checkBit({step, ".expired"}, expired, 1'b0);
        checkBit({step, ".time_up"}, time_up, 1'b0);
        checkBit({step, ".warning"}, warning, 1'b0);
        checkBit({step, ".warn_blink"}, warn_blink, 1'b0);
    endtask

    // Directed scenarios followed by a randomized run against the model
    initial begin
        bit last_tick;
        bit t, s, p, a;
        resetN = 0; tick = 0; start = 0; pause_tgl = 0; add_time = 0;
        modelReset();
        #1;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        resetN = 1;

        // Ticks without start are ignored
        for (int i = 0; i < 3; i++) stepCheck("idle_tick", 1, 0, 0, 0);
        stepCheck("idle_settle", 0, 0, 0, 0);

        // Full countdown to expiry
        stepCheck("start1", 0, 1, 0, 0);
        stepCheck("start1_show", 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            stepCheck("count_tick", 1, 0, 0, 0);
            stepCheck("count_gap", 0, 0, 0, 0);
        end
        checkBit("expired_after5", expired, 1'b1);
        stepCheck("sixth_tick", 1, 0, 0, 0);
        stepCheck("sixth_gap", 0, 0, 0, 0);
        checkNib("sixth_sec_ones", sec_ones, 4'd0);

        // Pause discards ticks; warning and blink at rem=2
        stepCheck("start2", 0, 1, 0, 0);
        stepCheck("p_tick", 1, 0, 0, 0);
        stepCheck("p_tick", 1, 0, 0, 0);
        stepCheck("pause_on", 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) stepCheck("paused_tick", 1, 0, 0, 0);
        checkNib("paused_sec_ones", sec_ones, 4'd3);
        stepCheck("pause_off", 0, 0, 1, 0);
        stepCheck("resume_tick", 1, 0, 0, 0);
        checkBit("warn_at2", warning, 1'b1);
        checkBit("blink_at2", warn_blink, 1'b1);
        stepCheck("resume_show", 0, 0, 0, 0);

        // Tick colliding with a bonus
        stepCheck("start3", 0, 1, 0, 0);
        stepCheck("start3_show", 0, 0, 0, 0);
        stepCheck("tick_add", 1, 0, 0, 1);
        stepCheck("pending_apply", 0, 0, 0, 0);
        checkBit("pending_running", running, 1'b1);
        stepCheck("pending_show", 0, 0, 0, 0);
        checkNib("pending_sec_ones", sec_ones, 4'd7);

        // Saturation at 99:59
        stepCheck("start4", 0, 1, 0, 0);
        for (int i = 0; i < 1998; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("fill");
        stepCheck("to5998", 1, 0, 0, 0);
        stepCheck("sat_add", 0, 0, 0, 1);
        stepCheck("sat_show", 0, 0, 0, 0);
        checkNib("sat_min_tens", min_tens, 4'd9);
        checkNib("sat_sec_ones", sec_ones, 4'd9);
        stepCheck("sat_again", 0, 0, 0, 1);
        stepCheck("sat_again_show", 0, 0, 0, 0);

        // Asynchronous reset mid-round
        stepCheck("start5", 0, 1, 0, 0);
        stepCheck("r_tick", 1, 0, 0, 0);
        stepCheck("r_show", 0, 0, 0, 0);
        #2;
        resetN = 0;
        #1;
        checkAllZero("async_reset");
        modelReset();
        @(posedge clk);
        #1;
        resetN = 1;
        checkOutput("post_reset");
        stepCheck("start6", 0, 1, 0, 0);
        stepCheck("start6_show", 0, 0, 0, 0);
        checkNib("reload_sec_ones", sec_ones, 4'd5);

        // Randomized run; ticks never land on consecutive cycles
        last_tick = 0;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 39) == 0);
            t = !last_tick && ($urandom_range(0, 1) == 1);
            p = ($urandom_range(0, 14) == 0);
            a = ($urandom_range(0, 19) == 0);
            last_tick = t;
            stepCheck("rand", t, s, p, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
